// File: rtl/sram_bw_sim_pkg.sv
// Shared types and helpers for the byte-writable simple-dual-port SRAM model.
// Byte merge works on a fixed maximum width so one function serves every instance width.
package sram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int MAX_DW = 1024;
  localparam int MAX_IW = 10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Lanes whose enable bit is set take new_w, the rest keep old_w.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_DW-1:0] be,
                                                   input int                bw);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int b = 0; b < MAX_DW; b++) begin
      if (be[MAX_IW'(b / bw)]) res[MAX_IW'(b)] = new_w[MAX_IW'(b)];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_bw_sim_if.sv
// Write/read port bundle of the SRAM model; master is the requester, slave the memory.
interface sram_bw_sim_if #(
  parameter int AW = 10,
  parameter int DW = 128,
  parameter int BW = 8
);
  localparam int NB = DW / BW;

  logic          init_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  init_done, rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output init_done, rd_data, rd_valid
  );
endinterface

// File: rtl/sram_bw_sim_rd_pipe.sv
// Read-data delay line of RD_LAT-1 stages sitting between the array read and the output register.
// Only valids are reset so in-flight reads are dropped; data stages run free.
module sram_rd_pipe #(
  parameter int DW     = 128,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);

  if (RD_LAT <= 1) begin : g_bypass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst};
    assign o_vld    = i_vld;
    assign o_data   = i_data;
  end else begin : g_pipe
    for (genvar g = 0; g < RD_LAT - 1; g++) begin : g_stage
      logic          r_vld_p;
      logic [DW-1:0] r_data_p;
      logic          w_vld_in;
      logic [DW-1:0] w_data_in;

      if (g == 0) begin : g_src
        assign w_vld_in  = i_vld;
        assign w_data_in = i_data;
      end else begin : g_src
        assign w_vld_in  = g_stage[g-1].r_vld_p;
        assign w_data_in = g_stage[g-1].r_data_p;
      end

      always_ff @(posedge clk) begin
        if (rst) r_vld_p <= 1'b0;
        else     r_vld_p <= w_vld_in;
      end

      always_ff @(posedge clk) begin
        r_data_p <= w_data_in;
      end
    end

    assign o_vld  = g_stage[RD_LAT-2].r_vld_p;
    assign o_data = g_stage[RD_LAT-2].r_data_p;
  end

endmodule

// File: rtl/sram_bw_sim.sv
// Behavioural simple-dual-port SRAM with byte enables, RD_LAT-deep read pipe,
// selectable read-during-write behaviour and an optional post-reset zero sweep.
module sram_bw_sim
  import sram_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 128,
  parameter int BW         = 8,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic clk,
  input  logic rst,
  sram_bw_sim_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_init_done;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [DW-1:0] w_wr_word;
  logic [DW-1:0] w_rd_word;
  logic          w_pipe_vld;
  logic [DW-1:0] w_pipe_data;

  // The reset edge itself never touches the array or launches a read.
  assign w_wr_acc  = bus.wr_en & r_init_done & ~rst;
  assign w_rd_acc  = bus.rd_en & r_init_done & ~rst;
  assign w_wr_word = DW'(byte_merge(MAX_DW'(r_mem[bus.wr_addr]), MAX_DW'(bus.wr_data),
                                    MAX_DW'(bus.wr_be), BW));
  assign w_rd_word = ((RDW_MODE == RDW_WRITE_FIRST) && w_wr_acc && (bus.wr_addr == bus.rd_addr))
                     ? w_wr_word : r_mem[bus.rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      r_cnt       <= '0;
      r_init_done <= (CLR_ON_RST == 0);
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_CLEAR) r_mem[r_cnt]       <= '0;
    else if (w_wr_acc)               r_mem[bus.wr_addr] <= w_wr_word;
  end

  // Stage p0 is the array read above; the pipe adds RD_LAT-1 stages before the output register.
  sram_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_rd_acc),
    .i_data (w_rd_word),
    .o_vld  (w_pipe_vld),
    .o_data (w_pipe_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_pipe_vld;
      if (w_pipe_vld) r_rd_data <= w_pipe_data;
    end
  end

  assign bus.init_done = r_init_done;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;

endmodule

// File: tb/tb_sram_bw_sim.sv
// Directed bench: three SRAM instances (RD_LAT 1/3/4, read-first/write-first) share one stimulus.
module tb_sram_bw_sim;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bw_sim_if #(.AW(4), .DW(32), .BW(8)) b0 ();
  sram_bw_sim_if #(.AW(4), .DW(32), .BW(8)) b1 ();
  sram_bw_sim_if #(.AW(4), .DW(32), .BW(8)) b2 ();

  assign b0.wr_en = wr_en; assign b0.wr_addr = wr_addr; assign b0.wr_data = wr_data;
  assign b0.wr_be = wr_be; assign b0.rd_en   = rd_en;   assign b0.rd_addr = rd_addr;
  assign b1.wr_en = wr_en; assign b1.wr_addr = wr_addr; assign b1.wr_data = wr_data;
  assign b1.wr_be = wr_be; assign b1.rd_en   = rd_en;   assign b1.rd_addr = rd_addr;
  assign b2.wr_en = wr_en; assign b2.wr_addr = wr_addr; assign b2.wr_data = wr_data;
  assign b2.wr_be = wr_be; assign b2.rd_en   = rd_en;   assign b2.rd_addr = rd_addr;

  sram_bw_sim #(.AW(4), .DW(32), .BW(8), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1))
    u_lat1 (.clk(clk), .rst(rst), .bus(b0));
  sram_bw_sim #(.AW(4), .DW(32), .BW(8), .RD_LAT(3), .RDW_MODE(1), .CLR_ON_RST(1))
    u_lat3 (.clk(clk), .rst(rst), .bus(b1));
  sram_bw_sim #(.AW(4), .DW(32), .BW(8), .RD_LAT(4), .RDW_MODE(0), .CLR_ON_RST(1))
    u_lat4 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sixteen sweep edges after reset release; init_done must rise on exactly the last one.
  task automatic clear_wait(input string tag);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("%s_done0[%0d]", tag, i), 32'(b0.init_done), 32'(i == 16));
      chk($sformatf("%s_done2[%0d]", tag, i), 32'(b2.init_done), 32'(i == 16));
      chk($sformatf("%s_vld0[%0d]", tag, i), 32'(b0.rd_valid), 32'h0);
      chk($sformatf("%s_vld2[%0d]", tag, i), 32'(b2.rd_valid), 32'h0);
      if (i == 16) wr_en = 1'b0;
    end
  endtask

  task automatic read_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      step();
      chk($sformatf("%s_vld[%0d]", tag, a), 32'(b0.rd_valid), 32'h1);
      chk($sformatf("%s_data[%0d]", tag, a), b0.rd_data, 32'h0);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd0;

    // Reset values, then clear sweep with both request lines held high.
    step();
    chk("rst_done", 32'(b0.init_done), 32'h0);
    chk("rst_vld", 32'(b0.rd_valid), 32'h0);
    chk("rst_data", b0.rd_data, 32'h0);
    rst = 1'b0;
    clear_wait("clr");
    read_zero("clr_rd");

    // Byte mask, including an all-lanes-off write that must change nothing.
    for (int i = 0; i < 4; i++) step();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'hF; step();
    wr_data = 32'h000000AB; wr_be = 4'h1; step();
    wr_data = 32'h12345678; wr_be = 4'h0; step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd3; step();
    chk("bm_vld", 32'(b0.rd_valid), 32'h1);
    chk("bm_data", b0.rd_data, 32'hFFFFFFAB);
    rd_en = 1'b0; step();
    chk("bm_hold_vld", 32'(b0.rd_valid), 32'h0);
    chk("bm_hold_data", b0.rd_data, 32'hFFFFFFAB);

    // Latency: three back-to-back reads through the RD_LAT=3 instance.
    wr_en = 1'b1; wr_be = 4'hF;
    wr_addr = 4'd1; wr_data = 32'h11; step();
    wr_addr = 4'd2; wr_data = 32'h22; step();
    wr_addr = 4'd3; wr_data = 32'h33; step();
    wr_en = 1'b0; rd_en = 1'b1;
    rd_addr = 4'd1; step();
    chk("lat_n0_vld3", 32'(b1.rd_valid), 32'h0);
    chk("lat_n0_data1", b0.rd_data, 32'h11);
    rd_addr = 4'd2; step();
    chk("lat_n1_vld3", 32'(b1.rd_valid), 32'h0);
    rd_addr = 4'd3; step();
    chk("lat_n2_vld3", 32'(b1.rd_valid), 32'h1);
    chk("lat_n2_data3", b1.rd_data, 32'h11);
    rd_en = 1'b0; step();
    chk("lat_n3_vld3", 32'(b1.rd_valid), 32'h1);
    chk("lat_n3_data3", b1.rd_data, 32'h22);
    chk("lat_n3_data4", b2.rd_data, 32'h11);
    step();
    chk("lat_n4_vld3", 32'(b1.rd_valid), 32'h1);
    chk("lat_n4_data3", b1.rd_data, 32'h33);
    step();
    chk("lat_n5_vld3", 32'(b1.rd_valid), 32'h0);
    chk("lat_n5_hold3", b1.rd_data, 32'h33);

    // Collision on address 5.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h11; step();
    wr_data = 32'h22; rd_en = 1'b1; rd_addr = 4'd5; step();
    chk("col_rf_vld", 32'(b0.rd_valid), 32'h1);
    chk("col_rf_data", b0.rd_data, 32'h11);
    wr_en = 1'b0; step();
    chk("col_next_lat1", b0.rd_data, 32'h22);
    rd_en = 1'b0; step();
    chk("col_wf_vld", 32'(b1.rd_valid), 32'h1);
    chk("col_wf_data", b1.rd_data, 32'h22);
    chk("col_idle_vld1", 32'(b0.rd_valid), 32'h0);
    step();
    chk("col_next_lat3", b1.rd_data, 32'h22);
    chk("col_rf4_vld", 32'(b2.rd_valid), 32'h1);
    chk("col_rf4_data", b2.rd_data, 32'h11);
    step();
    chk("col_next_lat4", b2.rd_data, 32'h22);
    chk("col_end_vld3", 32'(b1.rd_valid), 32'h0);

    // Reset with three reads in flight in the RD_LAT=4 pipe.
    for (int i = 0; i < 4; i++) step();
    rd_en = 1'b1;
    rd_addr = 4'd1; step();
    rd_addr = 4'd2; step();
    rd_addr = 4'd3; step();
    chk("pf_pre_vld4", 32'(b2.rd_valid), 32'h0);
    rst = 1'b1; rd_en = 1'b0; step();
    chk("pf_rst_vld4", 32'(b2.rd_valid), 32'h0);
    chk("pf_rst_data4", b2.rd_data, 32'h0);
    chk("pf_rst_vld3", 32'(b1.rd_valid), 32'h0);
    chk("pf_rst_done", 32'(b0.init_done), 32'h0);
    rst = 1'b0;

    // Eight clear edges, then reset again mid-sweep; requests stay high throughout.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd7;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("mc_vld4[%0d]", i), 32'(b2.rd_valid), 32'h0);
      chk($sformatf("mc_vld3[%0d]", i), 32'(b1.rd_valid), 32'h0);
      chk($sformatf("mc_done[%0d]", i), 32'(b0.init_done), 32'h0);
    end
    rst = 1'b1; step();
    rst = 1'b0;
    clear_wait("mc");
    read_zero("mc_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
